// File: rtl/mesh_sorter_if.sv
// mesh_sorter_if: result bus of the mesh sorter (done flag plus per-PE results).
// Build macro MESH_SORT_STATS_EN adds the sort_steps / swap_count statistics.
interface mesh_sorter_if #(
    parameter int unsigned N     = 64,
    parameter int unsigned WIDTH = 38
);
    logic                   done;
    logic [N*(WIDTH+1)-1:0] results;
`ifdef MESH_SORT_STATS_EN
    logic [15:0]            sort_steps;
    logic [31:0]            swap_count;

    modport master (output done, results, sort_steps, swap_count);
    modport slave  (input  done, results, sort_steps, swap_count);
`else
    modport master (output done, results);
    modport slave  (input  done, results);
`endif
endinterface

// File: rtl/mesh_sorter.sv
// mesh_sorter: N-PE mesh routing self-generated records to their home PE via snake-order
// odd-even transposition sort. Build macro MESH_SORT_STATS_EN enables the step/swap counters.

module mesh_pe_app #(
    parameter int unsigned K          = 0,
    parameter int unsigned N          = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_fin,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_rec,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_init_rec_c,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]   o_result
);
    localparam int unsigned WIDTH = ADDR_WIDTH + DATA_WIDTH;

    logic [WIDTH:0] nanci_result;

    assign o_init_rec_c = {ADDR_WIDTH'(N - 1 - K), DATA_WIDTH'(K)};
    assign o_result     = nanci_result;

    // Result is published once, on the edge where the controller finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nanci_result <= {1'b1, WIDTH'(0)};
        end else if (i_fin) begin
            nanci_result <= {1'b0, i_rec};
        end
    end
endmodule

module mesh_pe #(
    parameter int unsigned K          = 0,
    parameter int unsigned RANK       = 0,
    parameter int unsigned N          = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_load,
    input  logic                             i_step,
    input  logic                             i_odd,
    input  logic                             i_fin,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_prev_rec,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_next_rec,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_rec,
    output logic                             o_xchg_c,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]   o_result
);
    localparam int unsigned WIDTH    = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned HALF     = ADDR_WIDTH / 2;
    localparam bit          HAS_PREV = (RANK > 0);
    localparam bit          HAS_NEXT = (RANK < N - 1);
    localparam bit          RANK_ODD = ((RANK % 2) == 1);

    logic [WIDTH-1:0] r_rec;
    logic [WIDTH-1:0] w_rec_next;
    logic [WIDTH-1:0] w_init;
    logic             w_lower;

    // Odd rows run right-to-left along the snake, so their column bits are mirrored.
    function automatic logic [ADDR_WIDTH-1:0] key_of(input logic [ADDR_WIDTH-1:0] a);
        if (a[HALF]) key_of = {a[ADDR_WIDTH-1:HALF], ~a[HALF-1:0]};
        else         key_of = a;
    endfunction

    always_comb begin
        w_rec_next = r_rec;
        o_xchg_c   = 1'b0;
        w_lower    = (RANK_ODD == i_odd);
        if (w_lower) begin
            if (HAS_NEXT && (key_of(i_next_rec[WIDTH-1 -: ADDR_WIDTH]) <
                             key_of(r_rec[WIDTH-1 -: ADDR_WIDTH]))) begin
                w_rec_next = i_next_rec;
                o_xchg_c   = 1'b1;
            end
        end else if (HAS_PREV && (key_of(r_rec[WIDTH-1 -: ADDR_WIDTH]) <
                                  key_of(i_prev_rec[WIDTH-1 -: ADDR_WIDTH]))) begin
            w_rec_next = i_prev_rec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec <= '0;
        end else if (i_load) begin
            r_rec <= w_init;
        end else if (i_step) begin
            r_rec <= w_rec_next;
        end
    end

    assign o_rec = r_rec;

    mesh_pe_app #(
        .K          (K),
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) app_init (
        .clk          (clk),
        .rst          (rst),
        .i_fin        (i_fin),
        .i_rec        (w_rec_next),
        .o_init_rec_c (w_init),
        .o_result     (o_result)
    );
endmodule

module mesh_sorter #(
    parameter int unsigned N           = 64,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SORT_CYCLES = 53
) (
    input  logic         clk,
    input  logic         rst,
    mesh_sorter_if.master o_bus
);
    localparam int unsigned WIDTH    = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned SIDE     = 1 << (ADDR_WIDTH / 2);
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STEP_MAX = N + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SORT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Snake rank of a PE index; the mapping is its own inverse.
    function automatic int unsigned rank_of(input int unsigned k);
        int unsigned r;
        int unsigned c;
        r = k / SIDE;
        c = k % SIDE;
        rank_of = ((r % 2) == 1) ? (r * SIDE + SIDE - 1 - c) : k;
    endfunction

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   r_xchg_last;
    logic                   r_done;
    logic                   w_load_c;
    logic                   w_step_c;
    logic                   w_fin_c;
    logic                   w_exit;
    logic                   w_xchg_any;
    logic [WIDTH-1:0]       w_rec [N];
    logic [N-1:0]           w_xchg;
    logic [N*(WIDTH+1)-1:0] w_results;

    for (genvar k = 0; k < N; k++) begin : GEN
        localparam int unsigned KU      = k;
        localparam int unsigned RANK    = rank_of(KU);
        localparam int unsigned PREV_PE = (RANK > 0)     ? rank_of(RANK - 1) : KU;
        localparam int unsigned NEXT_PE = (RANK < N - 1) ? rank_of(RANK + 1) : KU;
        if (KU < N) begin : GENIF
            mesh_pe #(
                .K          (KU),
                .RANK       (RANK),
                .N          (N),
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) PE (
                .clk        (clk),
                .rst        (rst),
                .i_load     (w_load_c),
                .i_step     (w_step_c),
                .i_odd      (r_cnt[0]),
                .i_fin      (w_fin_c),
                .i_prev_rec (w_rec[PREV_PE]),
                .i_next_rec (w_rec[NEXT_PE]),
                .o_rec      (w_rec[k]),
                .o_xchg_c   (w_xchg[k]),
                .o_result   (w_results[k*(WIDTH+1) +: WIDTH+1])
            );
        end
    end

    assign w_xchg_any = |w_xchg;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    // Two clean steps in a row (one even, one odd) mean the whole snake is ordered.
    assign w_exit = ((w_cnt_inc >= CNT_W'(SORT_CYCLES)) && (r_cnt != '0) &&
                     !w_xchg_any && !r_xchg_last) ||
                    (w_cnt_inc >= CNT_W'(STEP_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_c     = 1'b0;
        w_step_c     = 1'b0;
        w_fin_c      = 1'b0;
        case (r_state)
            S_IDLE: w_state_next = S_LOAD;
            S_LOAD: begin
                w_load_c     = 1'b1;
                w_state_next = S_SORT;
            end
            S_SORT: begin
                w_step_c = 1'b1;
                if (w_exit) begin
                    w_fin_c      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_xchg_last <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_step_c) begin
                r_cnt       <= w_cnt_inc;
                r_xchg_last <= w_xchg_any;
            end
            if (w_fin_c) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_bus.done    = r_done;
    assign o_bus.results = w_results;

`ifdef MESH_SORT_STATS_EN
    logic [31:0] r_swaps;
    logic [31:0] w_swaps_step;

    // Only the lower PE of each pair flags, so this counts each exchange once.
    always_comb begin
        w_swaps_step = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_swaps_step = w_swaps_step + 32'(w_xchg[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_swaps <= '0;
        else if (w_step_c) r_swaps <= r_swaps + w_swaps_step;
    end

    assign o_bus.sort_steps = r_cnt;
    assign o_bus.swap_count = r_swaps;
`endif
endmodule

// File: tb/tb_mesh_sorter.sv
// tb_mesh_sorter: scoreboard bench for mesh_sorter at N=64 and N=16, with an algorithmic
// model of the snake transposition sort giving the expected step and swap counts.
module tb_mesh_sorter;
    localparam int unsigned N     = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned SC    = 53;
    localparam int unsigned W     = AW + DW;
    localparam int unsigned RW    = W + 1;
    localparam int unsigned SIDE  = 8;
    localparam int unsigned N2    = 16;
    localparam int unsigned AW2   = 4;
    localparam int unsigned SC2   = 4;
    localparam int unsigned W2    = AW2 + DW;
    localparam int unsigned RW2   = W2 + 1;
    localparam int unsigned SIDE2 = 4;

    localparam logic [RW-1:0]  EMPTY  = {1'b1, {W{1'b0}}};
    localparam logic [RW2-1:0] EMPTY2 = {1'b1, {W2{1'b0}}};

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [RW-1:0]  sb_q[$];
    logic [RW2-1:0] sb2_q[$];
    logic [RW-1:0]  probe [N];

    always #5 clk = ~clk;

    mesh_sorter_if #(.N(N),  .WIDTH(W))  bus ();
    mesh_sorter_if #(.N(N2), .WIDTH(W2)) bus2 ();

    mesh_sorter #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SORT_CYCLES(SC)) dut (
        .clk   (clk),
        .rst   (rst),
        .o_bus (bus)
    );

    mesh_sorter #(.N(N2), .ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .SORT_CYCLES(SC2)) dut2 (
        .clk   (clk),
        .rst   (rst2),
        .o_bus (bus2)
    );

    for (genvar k = 0; k < N; k++) begin : PROBE
        assign probe[k] = dut.GEN[k].GENIF.PE.app_init.nanci_result;
    end

    function automatic int snake(input int a, input int side);
        int r;
        int c;
        r = a / side;
        c = a % side;
        return ((r % 2) == 1) ? (r * side + side - 1 - c) : a;
    endfunction

    // Reference odd-even transposition sort over snake ranks with the early-exit rule.
    task automatic model_sort(input int n, input int side, input int sc,
                              output int steps, output int swaps);
        int key [64];
        int prev_x;
        int x;
        int t;
        for (int j = 0; j < n; j++) key[j] = snake(n - 1 - snake(j, side), side);
        steps  = 0;
        swaps  = 0;
        prev_x = 0;
        for (int s = 0; s < n + 2; s++) begin
            x = 0;
            for (int j = s % 2; j + 1 < n; j += 2) begin
                if (key[j+1] < key[j]) begin
                    t = key[j]; key[j] = key[j+1]; key[j+1] = t;
                    x++;
                end
            end
            steps++;
            swaps += x;
            if ((steps >= sc && s > 0 && x == 0 && prev_x == 0) || steps >= n + 2) break;
            prev_x = x;
        end
    endtask

    function automatic logic [RW-1:0] exp64(input int k);
        return {1'b0, AW'(k), DW'(N - 1 - k)};
    endfunction

    function automatic logic [RW2-1:0] exp16(input int k);
        return {1'b0, AW2'(k), DW'(N2 - 1 - k)};
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b exp 0", bus.done);
        end
        checks++;
        if (bus2.done !== 1'b0) begin
            errors++; $display("FAIL reset_done16 got %b exp 0", bus2.done);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (bus.results[k*RW +: RW] !== EMPTY || probe[k] !== EMPTY) begin
                errors++;
                $display("FAIL reset_result pe %0d got %h probe %h exp %h",
                         k, bus.results[k*RW +: RW], probe[k], EMPTY);
            end
        end
        for (int k = 0; k < N2; k++) begin
            checks++;
            if (bus2.results[k*RW2 +: RW2] !== EMPTY2) begin
                errors++;
                $display("FAIL reset_result16 pe %0d got %h exp %h",
                         k, bus2.results[k*RW2 +: RW2], EMPTY2);
            end
        end
    endtask

    task automatic test_sort(input string tag);
        int          cyc;
        int          steps;
        int          swaps;
        bit          seen;
        logic [RW-1:0] exp;
        logic [N-1:0]  mismatch;
        model_sort(N, SIDE, SC, steps, swaps);
        for (int k = 0; k < N; k++) sb_q.push_back(exp64(k));
        @(negedge clk);
        rst  = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (bus.results[k*RW +: RW] !== EMPTY) begin
                        errors++;
                        $display("FAIL %s_predone pe %0d cyc %0d got %h exp %h",
                                 tag, k, cyc, bus.results[k*RW +: RW], EMPTY);
                    end
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s_timeout done got 0 exp 1 within 200 cycles", tag);
        end
        checks++;
        if (cyc != 2 + steps) begin
            errors++; $display("FAIL %s_latency got %0d exp %0d", tag, cyc, 2 + steps);
        end
        checks++;
        if (cyc < 2 + SC || cyc > 2 + N + 2) begin
            errors++;
            $display("FAIL %s_latency_range got %0d exp %0d..%0d", tag, cyc, 2 + SC, 2 + N + 2);
        end
        mismatch = '0;
        for (int k = 0; k < N; k++) begin
            exp = sb_q.pop_front();
            checks++;
            if (bus.results[k*RW +: RW] !== exp || probe[k] !== exp) begin
                mismatch[k] = 1'b1;
                errors++;
                $display("FAIL %s_result pe %0d got %h probe %h exp %h",
                         tag, k, bus.results[k*RW +: RW], probe[k], exp);
            end
        end
        checks++;
        if (mismatch !== '0) begin
            errors++; $display("FAIL %s_mismatch_vec got %h exp 0", tag, mismatch);
        end
`ifdef MESH_SORT_STATS_EN
        checks++;
        if (bus.sort_steps !== 16'(steps)) begin
            errors++; $display("FAIL %s_sort_steps got %0d exp %0d", tag, bus.sort_steps, steps);
        end
        checks++;
        if (bus.swap_count !== 32'(swaps) || swaps == 0) begin
            errors++; $display("FAIL %s_swap_count got %0d exp %0d", tag, bus.swap_count, swaps);
        end
`endif
    endtask

    task automatic test_hold();
        int steps;
        int swaps;
        model_sort(N, SIDE, SC, steps, swaps);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b1) begin
                errors++; $display("FAIL hold_done cyc %0d got %b exp 1", i, bus.done);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (bus.results[k*RW +: RW] !== exp64(k)) begin
                    errors++;
                    $display("FAIL hold_result cyc %0d pe %0d got %h exp %h",
                             i, k, bus.results[k*RW +: RW], exp64(k));
                end
            end
`ifdef MESH_SORT_STATS_EN
            checks++;
            if (bus.sort_steps !== 16'(steps) || bus.swap_count !== 32'(swaps)) begin
                errors++;
                $display("FAIL hold_stats cyc %0d got %0d/%0d exp %0d/%0d",
                         i, bus.sort_steps, bus.swap_count, steps, swaps);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0) begin
                errors++; $display("FAIL mid_early_done cyc %0d got %b exp 0", i, bus.done);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_done got %b exp 0", bus.done);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (bus.results[k*RW +: RW] !== EMPTY || probe[k] !== EMPTY) begin
                errors++;
                $display("FAIL mid_reset_result pe %0d got %h probe %h exp %h",
                         k, bus.results[k*RW +: RW], probe[k], EMPTY);
            end
        end
`ifdef MESH_SORT_STATS_EN
        checks++;
        if (bus.sort_steps !== 16'd0 || bus.swap_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_stats got %0d/%0d exp 0/0", bus.sort_steps, bus.swap_count);
        end
`endif
        @(negedge clk);
        test_sort("rerun");
    endtask

    task automatic test_small();
        int            cyc;
        int            steps;
        int            swaps;
        bit            seen;
        logic [RW2-1:0] exp;
        model_sort(N2, SIDE2, SC2, steps, swaps);
        for (int k = 0; k < N2; k++) sb2_q.push_back(exp16(k));
        @(negedge clk);
        rst2 = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus2.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL small_timeout done got 0 exp 1 within 100 cycles");
        end
        checks++;
        if (cyc != 2 + steps || cyc < 2 + SC2 || cyc > 2 + N2 + 2) begin
            errors++;
            $display("FAIL small_latency got %0d exp %0d (bound %0d..%0d)",
                     cyc, 2 + steps, 2 + SC2, 2 + N2 + 2);
        end
        for (int k = 0; k < N2; k++) begin
            exp = sb2_q.pop_front();
            checks++;
            if (bus2.results[k*RW2 +: RW2] !== exp) begin
                errors++;
                $display("FAIL small_result pe %0d got %h exp %h",
                         k, bus2.results[k*RW2 +: RW2], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sort("first");
        test_hold();
        test_mid_reset();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesh_sorter.md
Name: mesh_sorter

Overview:
- Self-contained array of N processing elements (PEs) on a sqrt(N) x sqrt(N) grid.
- It routes records to their destinations by sorting. After reset, every PE generates one record. The array sorts the records over nearest-neighbour links in snake (boustrophedon) order, keyed on destination address.
- PE k ends holding the record addressed to k.
- Used as the top-level sorting-network demonstrator; hierarchical probes read each PE's result.

Parameters:
- N, 64, number of PEs; must be a perfect square with even side length S = sqrt(N).
- ADDR_WIDTH, 6, address field width; equals log2(N).
- DATA_WIDTH, 32, data field width.
- SORT_CYCLES, 53, minimum number of compare-exchange steps before early termination is permitted.
- WIDTH (localparam), ADDR_WIDTH+DATA_WIDTH, record width.

Ports:
- clk  input  1  single system clock; all state is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- done  output  1  high once sorting has finished; holds until the next reset.
- results  output  N*(WIDTH+1)  concatenated PE results; slice k is PE k's nanci_result.

Behaviour:
- PE index and position: k = row*S + col.
- Snake rank of position (r,c): r*S + c for even r; r*S + (S-1-c) for odd r. Consecutive snake ranks are always physical mesh neighbours.
- Record format: {addr[ADDR_WIDTH-1:0], data[DATA_WIDTH-1:0]}.
- Sort key: snake_rank(addr).
- Initial record at PE k: addr = N-1-k, data = k.
- nanci_result is WIDTH+1 bits: {empty, addr, data}. empty=1 means no valid result.
- Reset: while rst is high, nanci_result = {1'b1, 0...0} in every PE, done=0, step counter=0, controller in IDLE.
- Controller FSM, states IDLE -> LOAD -> SORT -> DONE:
  - IDLE: first clk after rst deasserts -> LOAD.
  - LOAD: 1 cycle; each PE latches its initial record -> SORT.
  - SORT: one compare-exchange step per cycle.
    - Even steps (0,2,...) pair snake ranks (2i, 2i+1); odd steps pair (2i+1, 2i+2).
    - In each pair the smaller key moves to the lower snake rank.
    - Equal keys are impossible by construction; if they occur, no swap.
    - An exchange flag is OR-reduced across all PEs each step.
  - SORT exit: step count >= SORT_CYCLES AND the last two consecutive steps (one even, one odd) produced no exchange; or a hard ceiling of N+2 steps.
  - DONE: every PE copies its record into nanci_result with empty=0, on the same edge that done rises. Results then hold until reset.
- Result per PE after DONE: PE k holds {1'b0, k, N-1-k}.
- Latency: for N=64 with the initial pattern above, done rises no later than 2+66 cycles after rst deasserts.
- Reset mid-operation: asserting rst in any state immediately clears everything; the sequence restarts from IDLE on release.
- Hierarchy for bench probes: per-PE logic lives in generate loop GEN[k], conditional block GENIF, PE instance named PE, with a sub-instance app_init holding register nanci_result. GEN[k].GENIF.PE.app_init.nanci_result must resolve.
- Neighbour exchange uses only mesh-adjacent links: row-internal links plus one column link at each row end.

Optional Feature:
- Macro MESH_SORT_STATS_EN.
- When defined:
  - Adds output sort_steps [15:0], the number of SORT steps executed; frozen at DONE, 0 in reset.
  - Adds output swap_count [31:0], the total exchanges performed.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Defaults (N=64, SORT_CYCLES=53); rst high 2 cycles then low; wait 200 cycles -> done=1; every PE k holds {0, k, 63-k}, e.g. PE0 = {0,6'd0,32'd63} and PE63 = {0,6'd63,32'd0}; mismatch vector all zeros.
- Sample nanci_result of all PEs during reset and before done -> {1'b1, 0}; done=0.
- Count cycles from rst release to done -> between 2+SORT_CYCLES and 2+N+2 inclusive; results unchanged for 100 further cycles.
- Assert rst 30 cycles into SORT -> done=0 and results empty immediately; on release, the full run repeats with identical final results.
- N=16, ADDR_WIDTH=4, SORT_CYCLES=4 -> PE k holds {0, k, 15-k}; done within 2+18 cycles.
- With MESH_SORT_STATS_EN, defaults -> sort_steps in [53,66] and swap_count nonzero; frozen after done.
